// File: rtl/stop_pkg.sv
// Shared types and channel map for the stopwatch input front end.
// Imported by the conditioner, its per-channel debouncer, and the stopwatch top.
package stop_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } stop_state_e;

    localparam int CH_RESET = 0;
    localparam int CH_PAUSE = 1;
    localparam int CH_SEL   = 2;
    localparam int CH_ADJ   = 3;

    function automatic int stop_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/stop_input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw levels in, clean levels/pulses out.
// master = board/stimulus side, slave = conditioner side.
interface stop_input_conditioner_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic            pause_state;

    modport master (
        output raw_in,
        input  level_out,
        input  press_pulse,
        input  release_pulse,
        input  pause_state
    );

    modport slave (
        input  raw_in,
        output level_out,
        output press_pulse,
        output release_pulse,
        output pause_state
    );
endinterface

// File: rtl/stop_debounce_ch.sv
// One input channel: 2-flop synchroniser, debounce FSM with shared counter,
// registered level and press/release pulses, optional auto-repeat while held.
module stop_debounce_ch
    import stop_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 25000000,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(stop_max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       sync_q;
    logic             sync;
    stop_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic             rep_phase;

    assign sync = sync_q[1];

    // NOTE: non-blocking throughout so the synchroniser shifts exactly one stage per edge
    // and the FSM always acts on the previous edge's synchronised sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            state         <= STABLE_LO;
            cnt           <= '0;
            rep_phase     <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], raw};
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;

            case (state)
                STABLE_LO: begin
                    if (sync) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                    end
                end

                WAIT_HI: begin
                    if (!sync) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt >= DB_LAST) begin
                        state       <= STABLE_HI;
                        cnt         <= '0;
                        rep_phase   <= 1'b0;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                STABLE_HI: begin
                    if (!sync) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                    end else if (REPEAT_EN) begin
                        // First repeat after the long delay, then at the shorter period.
                        if (cnt >= (rep_phase ? RP_LAST : RD_LAST)) begin
                            cnt         <= '0;
                            rep_phase   <= 1'b1;
                            press_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end

                WAIT_LO: begin
                    if (sync) begin
                        state     <= STABLE_HI;
                        cnt       <= '0;
                        rep_phase <= 1'b0;
                    end else if (cnt >= DB_LAST) begin
                        state         <= STABLE_LO;
                        cnt           <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: state <= STABLE_LO;
            endcase
        end
    end

endmodule

// File: rtl/stop_input_conditioner.sv
// Stopwatch input front end: N_CH debounced channels plus the run/pause toggle.
// Define STOP_AUTOREPEAT_EN to auto-repeat press pulses on held non-control channels.
module stop_input_conditioner
    import stop_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 500000,
    parameter int PAUSE_CH      = CH_PAUSE,
    parameter int RESET_CH      = CH_RESET,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 25000000
) (
    input logic                     clk,
    input logic                     reset,
    stop_input_conditioner_if.slave bus
);

    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic            pause;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
`ifdef STOP_AUTOREPEAT_EN
        // A held reset or pause button must not re-trigger its action.
        localparam bit CH_REPEAT = (i != PAUSE_CH) && (i != RESET_CH);
`else
        localparam bit CH_REPEAT = 1'b0;
`endif
        stop_debounce_ch #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REPEAT_EN    (CH_REPEAT)
        ) u_ch (
            .clk          (clk),
            .rst_n        (reset),
            .raw          (bus.raw_in[i]),
            .level        (level[i]),
            .press_pulse  (press[i]),
            .release_pulse(rel[i])
        );
    end

    // Reset press dominates a simultaneous pause press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pause <= 1'b0;
        end else if (press[RESET_CH]) begin
            pause <= 1'b0;
        end else if (press[PAUSE_CH]) begin
            pause <= ~pause;
        end
    end

    assign bus.level_out     = level;
    assign bus.press_pulse   = press;
    assign bus.release_pulse = rel;
    assign bus.pause_state   = pause;

endmodule

// File: tb/tb_stop_input_conditioner.sv
// Directed bench for stop_input_conditioner with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stop_input_conditioner;
    import stop_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    stop_input_conditioner_if #(.N_CH(4)) bus ();

    stop_input_conditioner #(
        .N_CH         (4),
        .DB_CYCLES    (4),
        .PAUSE_CH     (CH_PAUSE),
        .RESET_CH     (CH_RESET),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance n cycles, counting press pulses seen on one channel.
    task automatic count_press(input int n, input int ch, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.press_pulse[ch]) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int lvl_changes;
        int mismatches;
        int first_rep;
        logic exp_rep;

        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.raw_in = 4'b0000;

        // Asynchronous reset with no clock edge involved.
        #1 reset = 1'b0;
        #1;
        check("rst_level", bus.level_out, 4'b0000);
        check("rst_press", bus.press_pulse, 4'b0000);
        check("rst_release", bus.release_pulse, 4'b0000);
        check("rst_pause", bus.pause_state, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(3);
        check("idle_level", bus.level_out, 4'b0000);

        // Clean press / release on the select channel: 6 edges each way.
        bus.raw_in[CH_SEL] = 1'b1;
        tick(5);
        check("clean_pre_level", bus.level_out, 4'b0000);
        check("clean_pre_press", bus.press_pulse, 4'b0000);
        tick(1);
        check("clean_level", bus.level_out, 4'b0100);
        check("clean_press", bus.press_pulse, 4'b0100);
        tick(1);
        check("clean_press_1cyc", bus.press_pulse, 4'b0000);
        check("clean_level_hold", bus.level_out, 4'b0100);
        tick(43);
        bus.raw_in[CH_SEL] = 1'b0;
        tick(5);
        check("clean_pre_fall_level", bus.level_out, 4'b0100);
        check("clean_pre_release", bus.release_pulse, 4'b0000);
        tick(1);
        check("clean_fall_level", bus.level_out, 4'b0000);
        check("clean_release", bus.release_pulse, 4'b0100);
        tick(1);
        check("clean_release_1cyc", bus.release_pulse, 4'b0000);
        tick(4);

        // Bounce on the adjust channel: 1,0,1,0 then hold 1.
        pulses = 0;
        bus.raw_in[CH_ADJ] = 1'b1;
        tick(1); if (bus.press_pulse[CH_ADJ]) pulses++;
        bus.raw_in[CH_ADJ] = 1'b0;
        tick(1); if (bus.press_pulse[CH_ADJ]) pulses++;
        bus.raw_in[CH_ADJ] = 1'b1;
        tick(1); if (bus.press_pulse[CH_ADJ]) pulses++;
        bus.raw_in[CH_ADJ] = 1'b0;
        tick(1); if (bus.press_pulse[CH_ADJ]) pulses++;
        bus.raw_in[CH_ADJ] = 1'b1;
        begin
            int early;
            count_press(5, CH_ADJ, early);
            pulses += early;
        end
        check("bounce_no_early_pulse", pulses[7:0], 8'd0);
        tick(1);
        check("bounce_press", bus.press_pulse, 4'b1000);
        count_press(15, CH_ADJ, pulses);
        check("bounce_single_pulse", pulses[7:0], 8'd0);
        bus.raw_in[CH_ADJ] = 1'b0;
        tick(10);
        check("bounce_released", bus.level_out, 4'b0000);

        // 3-cycle glitch must not change anything.
        bus.raw_in[CH_ADJ] = 1'b1;
        tick(3);
        bus.raw_in[CH_ADJ] = 1'b0;
        pulses = 0;
        lvl_changes = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.press_pulse[CH_ADJ] || bus.release_pulse[CH_ADJ]) pulses++;
            if (bus.level_out[CH_ADJ]) lvl_changes++;
        end
        check("glitch_pulses", pulses[7:0], 8'd0);
        check("glitch_level", lvl_changes[7:0], 8'd0);

        // Pause toggle: each change lands one cycle after its press pulse.
        bus.raw_in[CH_PAUSE] = 1'b1;
        tick(6);
        check("pause1_press", bus.press_pulse, 4'b0010);
        check("pause1_before", bus.pause_state, 1'b0);
        tick(1);
        check("pause1_after", bus.pause_state, 1'b1);
        bus.raw_in[CH_PAUSE] = 1'b0;
        tick(10);
        bus.raw_in[CH_PAUSE] = 1'b1;
        tick(6);
        check("pause2_before", bus.pause_state, 1'b1);
        tick(1);
        check("pause2_after", bus.pause_state, 1'b0);
        bus.raw_in[CH_PAUSE] = 1'b0;
        tick(10);
        bus.raw_in[CH_PAUSE] = 1'b1;
        tick(7);
        check("pause3_after", bus.pause_state, 1'b1);
        bus.raw_in[CH_PAUSE] = 1'b0;
        tick(10);

        // Reset and pause pressed together: reset wins.
        bus.raw_in[CH_RESET] = 1'b1;
        bus.raw_in[CH_PAUSE] = 1'b1;
        tick(6);
        check("both_press", bus.press_pulse, 4'b0011);
        tick(1);
        check("both_pause", bus.pause_state, 1'b0);
        bus.raw_in = 4'b0000;
        tick(10);

        // Async reset mid-operation: paused, ch3 level high, ch2 in WAIT_HI.
        bus.raw_in[CH_PAUSE] = 1'b1;
        tick(7);
        check("prereset_pause", bus.pause_state, 1'b1);
        bus.raw_in[CH_PAUSE] = 1'b0;
        tick(10);
        bus.raw_in[CH_ADJ] = 1'b1;
        tick(7);
        check("prereset_level", bus.level_out, 4'b1000);
        bus.raw_in[CH_SEL] = 1'b1;
        tick(3);
        #2 reset = 1'b0;
        #1;
        check("async_level", bus.level_out, 4'b0000);
        check("async_pause", bus.pause_state, 1'b0);
        check("async_press", bus.press_pulse, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        tick(5);
        check("rerelease_pre", bus.press_pulse, 4'b0000);
        tick(1);
        check("rerelease_press", bus.press_pulse, 4'b1100);
        check("rerelease_level", bus.level_out, 4'b1100);
        bus.raw_in = 4'b0000;
        tick(10);

        // Held channel 3: repeats only with the auto-repeat build.
        bus.raw_in[CH_ADJ] = 1'b1;
        tick(6);
        check("hold3_first", bus.press_pulse, 4'b1000);
        pulses = 0;
        mismatches = 0;
        first_rep = 0;
        for (int k = 1; k <= 54; k++) begin
            @(negedge clk);
`ifdef STOP_AUTOREPEAT_EN
            exp_rep = (k >= 20) && (((k - 20) % 8) == 0);
`else
            exp_rep = 1'b0;
`endif
            if (bus.press_pulse[CH_ADJ]) begin
                pulses++;
                if (first_rep == 0) first_rep = k;
            end
            if (bus.press_pulse[CH_ADJ] !== exp_rep) mismatches++;
        end
`ifdef STOP_AUTOREPEAT_EN
        check("hold3_repeat_count", pulses[7:0], 8'd5);
        check("hold3_first_repeat", first_rep[7:0], 8'd20);
`else
        check("hold3_repeat_count", pulses[7:0], 8'd0);
`endif
        check("hold3_timing", mismatches[7:0], 8'd0);
        bus.raw_in[CH_ADJ] = 1'b0;
        tick(10);

        // Held pause channel never repeats.
        bus.raw_in[CH_PAUSE] = 1'b1;
        count_press(60, CH_PAUSE, pulses);
        check("hold1_pulses", pulses[7:0], 8'd1);
        check("hold1_pause", bus.pause_state, 1'b1);
        bus.raw_in[CH_PAUSE] = 1'b0;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
